hub75_scan_driver: RTL and testbench

- Consumer of the PLL output clock; drives a HUB75 LED panel from a framebuffer RAM.
- Scans double-scan rows: shifts one column of upper- and lower-half pixel bits per hub_clk.
- Latches each row and gates OE with binary-coded modulation (BCM): bit-plane p is lit for BASE_ON<<p cycles.
- Sits between the framebuffer read port and the panel pins.

---
 rtl/hub75_pkg.sv | 30 +++
 rtl/hub75_bcm_timer.sv | 58 +++++
 rtl/hub75_scan_driver.sv | 178 +++++++++++++++++
 tb/tb_hub75_scan_driver.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// Shared types and width helpers for the HUB75 scan driver.
package hub75_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHIFT,
    BLANK,
    LATCH,
    DISPLAY
  } state_t;

  localparam int unsigned PIX_BITS = 8;

  // Native framebuffer word layout, upper-half pixel in the high bits
  typedef struct packed {
    logic [PIX_BITS-1:0] r1;
    logic [PIX_BITS-1:0] g1;
    logic [PIX_BITS-1:0] b1;
    logic [PIX_BITS-1:0] r2;
    logic [PIX_BITS-1:0] g2;
    logic [PIX_BITS-1:0] b2;
  } pixel_pair_t;

  // Wide enough to hold the longest plane's on-time, BASE_ON << (BITS-1)
  function automatic int unsigned disp_cnt_w(input int unsigned base_on, input int unsigned bits);
    return $clog2(base_on << (bits - 1)) + 1;
  endfunction

endpackage

// File: rtl/hub75_bcm_timer.sv
// BCM on-time timer: counts one DISPLAY period of BASE_ON<<plane cycles.
// With HUB75_BRIGHTNESS_EN defined, OE is only requested for a scaled prefix.
module hub75_bcm_timer
  import hub75_pkg::*;
#(
  parameter int unsigned BASE_ON = 32,
  parameter int unsigned BITS    = 8,
  parameter int unsigned PLANE_W = $clog2(BITS)
) (
  input  logic               clk,
  input  logic               reset,
`ifdef HUB75_BRIGHTNESS_EN
  input  logic [7:0]         brightness,
`endif
  input  logic               load,
  input  logic               run,
  input  logic [PLANE_W-1:0] plane,
  output logic               done,
  output logic               oe_active
);

  localparam int unsigned CNT_W = disp_cnt_w(BASE_ON, BITS);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] on_cnt;
  logic [CNT_W-1:0] total;
  logic [CNT_W-1:0] on_cycles;

  assign total = CNT_W'(BASE_ON) << plane;

`ifdef HUB75_BRIGHTNESS_EN
  localparam int unsigned PROD_W = CNT_W + 8;
  logic [PROD_W-1:0] prod;
  assign prod      = PROD_W'(total) * PROD_W'(brightness);
  assign on_cycles = CNT_W'(prod >> 8);
`else
  assign on_cycles = total;
`endif

  // cnt = cycles remaining after this one; on_cnt = OE-low cycles still owed
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      on_cnt <= '0;
    end else if (load) begin
      cnt    <= total - CNT_W'(1);
      on_cnt <= on_cycles;
    end else if (run) begin
      if (cnt != '0)    cnt    <= cnt - CNT_W'(1);
      if (on_cnt != '0) on_cnt <= on_cnt - CNT_W'(1);
    end
  end

  assign done = run && (cnt == '0);
  // Lookahead: whether OE should be low in the following cycle
  assign oe_active = load ? (on_cycles != '0) : (on_cnt > CNT_W'(1));

endmodule

// File: rtl/hub75_scan_driver.sv
// HUB75 double-scan panel driver: fetch/shift each row, latch, then BCM display.
// Optional HUB75_BRIGHTNESS_EN adds a global brightness input scaling OE time.
module hub75_scan_driver
  import hub75_pkg::*;
#(
  parameter int unsigned COLS      = 64,
  parameter int unsigned ROWS_HALF = 16,
  parameter int unsigned BITS      = 8,
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned BASE_ON   = 32,
  parameter int unsigned ADDR_W    = $clog2(ROWS_HALF),
  parameter int unsigned COL_W     = $clog2(COLS)
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic                    enable,
`ifdef HUB75_BRIGHTNESS_EN
  input  logic [7:0]              brightness,
`endif
  output logic                    fb_rd_en,
  output logic [ADDR_W+COL_W-1:0] fb_addr,
  input  logic [6*BITS-1:0]       fb_data,
  output logic [5:0]              hub_rgb,
  output logic                    hub_clk,
  output logic                    hub_lat,
  output logic                    hub_oe_n,
  output logic [ADDR_W-1:0]       hub_addr,
  output logic                    frame_done
);

  localparam int unsigned PLANE_W = $clog2(BITS);
  localparam int unsigned DIV_W   = $clog2(CLK_DIV);
  localparam int unsigned HALF    = CLK_DIV / 2;
  localparam int unsigned IDX_W   = $clog2(6 * BITS);

  state_t             state, state_n;
  logic [COL_W-1:0]   col, col_n;
  logic [ADDR_W-1:0]  row, row_n;
  logic [PLANE_W-1:0] plane, plane_n;
  logic [DIV_W-1:0]   div_cnt, div_n;
  logic               lat_cnt, lat_n;
  logic               tmr_load, tmr_run, tmr_done, tmr_oe;
  logic               frame_end;
  logic               rd_d, clk_d, lat_d;
  logic [5:0]         rgb_sel;

  assign tmr_run = (state == DISPLAY);

  hub75_bcm_timer #(
    .BASE_ON (BASE_ON),
    .BITS    (BITS),
    .PLANE_W (PLANE_W)
  ) u_bcm_timer (
    .clk        (clk_in),
    .reset      (reset),
`ifdef HUB75_BRIGHTNESS_EN
    .brightness (brightness),
`endif
    .load       (tmr_load),
    .run        (tmr_run),
    .plane      (plane),
    .done       (tmr_done),
    .oe_active  (tmr_oe)
  );

  // Current bit-plane of each channel; channel c occupies fb_data[c*BITS +: BITS]
  always_comb begin
    rgb_sel = '0;
    for (int c = 0; c < 6; c++) begin
      rgb_sel[c] = fb_data[IDX_W'(c * BITS) + IDX_W'(plane)];
    end
  end

  // Next-state, counter and registered-output decode
  always_comb begin
    state_n   = state;
    col_n     = col;
    row_n     = row;
    plane_n   = plane;
    div_n     = div_cnt;
    lat_n     = lat_cnt;
    tmr_load  = 1'b0;
    frame_end = 1'b0;

    case (state)
      IDLE: begin
        if (enable) state_n = FETCH;
      end
      FETCH: begin
        state_n = SHIFT;
        div_n   = '0;
      end
      SHIFT: begin
        if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
          div_n = '0;
          if (col == COL_W'(COLS - 1)) begin
            col_n   = '0;
            state_n = BLANK;
          end else begin
            col_n   = col + COL_W'(1);
            state_n = FETCH;
          end
        end else begin
          div_n = div_cnt + DIV_W'(1);
        end
      end
      BLANK: begin
        state_n = LATCH;
        lat_n   = 1'b0;
      end
      LATCH: begin
        if (lat_cnt) begin
          state_n  = DISPLAY;
          tmr_load = 1'b1;
        end else begin
          lat_n = 1'b1;
        end
      end
      DISPLAY: begin
        if (tmr_done) begin
          if (plane == PLANE_W'(BITS - 1)) begin
            plane_n = '0;
            if (row == ADDR_W'(ROWS_HALF - 1)) begin
              row_n     = '0;
              frame_end = 1'b1;
            end else begin
              row_n = row + ADDR_W'(1);
            end
          end else begin
            plane_n = plane + PLANE_W'(1);
          end
          state_n = enable ? FETCH : IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    rd_d  = (state_n == FETCH);
    clk_d = (state_n == SHIFT) && (div_n >= DIV_W'(HALF));
    lat_d = (state_n == LATCH);
  end

  // Pins are registered from the next-state decode so they line up with the state
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      plane      <= '0;
      div_cnt    <= '0;
      lat_cnt    <= 1'b0;
      fb_rd_en   <= 1'b0;
      fb_addr    <= '0;
      hub_rgb    <= '0;
      hub_clk    <= 1'b0;
      hub_lat    <= 1'b0;
      hub_oe_n   <= 1'b1;
      hub_addr   <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      col        <= col_n;
      row        <= row_n;
      plane      <= plane_n;
      div_cnt    <= div_n;
      lat_cnt    <= lat_n;
      fb_rd_en   <= rd_d;
      fb_addr    <= {row_n, col_n};
      if ((state == SHIFT) && (div_cnt == '0)) hub_rgb <= rgb_sel;
      hub_clk    <= clk_d;
      hub_lat    <= lat_d;
      hub_oe_n   <= !((state_n == DISPLAY) && tmr_oe);
      if (state == BLANK) hub_addr <= row;
      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Directed bench for hub75_scan_driver on a 4x(2x2) panel, 2 bit-planes.
module tb_hub75_scan_driver;

  localparam int unsigned COLS      = 4;
  localparam int unsigned ROWS_HALF = 2;
  localparam int unsigned BITS      = 2;
  localparam int unsigned CLK_DIV   = 2;
  localparam int unsigned BASE_ON   = 8;
  localparam int          TR_N      = 200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        fb_rd_en;
  logic [2:0]  fb_addr;
  logic [11:0] fb_data = '0;
  logic [5:0]  hub_rgb;
  logic        hub_clk, hub_lat, hub_oe_n, frame_done;
  logic [0:0]  hub_addr;
`ifdef HUB75_BRIGHTNESS_EN
  logic [7:0]  brightness = 8'd255;
`endif

  hub75_scan_driver #(
    .COLS(COLS), .ROWS_HALF(ROWS_HALF), .BITS(BITS), .CLK_DIV(CLK_DIV), .BASE_ON(BASE_ON)
  ) dut (
    .clk_in     (clk),
    .reset      (reset),
    .enable     (enable),
`ifdef HUB75_BRIGHTNESS_EN
    .brightness (brightness),
`endif
    .fb_rd_en   (fb_rd_en),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .hub_rgb    (hub_rgb),
    .hub_clk    (hub_clk),
    .hub_lat    (hub_lat),
    .hub_oe_n   (hub_oe_n),
    .hub_addr   (hub_addr),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Framebuffer: registered read, data valid the cycle after fb_rd_en
  logic [11:0] fb_mem [8];
  always @(posedge clk) if (fb_rd_en) fb_data <= fb_mem[fb_addr];

  typedef struct {
    logic [2:0] addr;
    logic [5:0] rgb;
  } vec_t;
  vec_t tbl [16];

  bit         tr_rd [TR_N];
  bit         tr_clk [TR_N];
  bit         tr_lat [TR_N];
  bit         tr_oe [TR_N];
  bit         tr_done [TR_N];
  bit         tr_haddr [TR_N];
  logic [2:0] tr_faddr [TR_N];
  logic [5:0] tr_rgb [TR_N];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tr_rd[i]    = fb_rd_en;
      tr_clk[i]   = hub_clk;
      tr_lat[i]   = hub_lat;
      tr_oe[i]    = hub_oe_n;
      tr_done[i]  = frame_done;
      tr_haddr[i] = hub_addr[0];
      tr_faddr[i] = fb_addr;
      tr_rgb[i]   = hub_rgb;
    end
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic bit hit(input int sig, input int k);
    case (sig)
      0: return tr_rd[k];
      1: return (k > 0) ? (tr_clk[k] && !tr_clk[k-1]) : 1'b0;
      2: return tr_lat[k];
      3: return !tr_oe[k];
      default: return tr_done[k];
    endcase
  endfunction

  function automatic int count(input int sig, input int lo, input int hi);
    int n = 0;
    for (int k = lo; k < hi; k++) n += int'(hit(sig, k));
    return n;
  endfunction

  function automatic int next_idx(input int sig, input int from);
    for (int k = from; k < TR_N; k++) if (hit(sig, k)) return k;
    return -1;
  endfunction

  function automatic int exp_on(input int p);
`ifdef HUB75_BRIGHTNESS_EN
    return ((int'(BASE_ON) << p) * int'(brightness)) >> 8;
`else
    return int'(BASE_ON) << p;
`endif
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  k;
    int  kc;
    bit  found;

    // {r1,g1,b1,r2,g2,b2} x 2 bits; b2 in [1:0]
    for (int i = 0; i < 8; i++) fb_mem[i] = '0;
    fb_mem[0] = 12'h400;  // r1 plane 0
    fb_mem[2] = 12'h080;  // b1 plane 1
    fb_mem[5] = 12'h008;  // g2 plane 1
    fb_mem[7] = 12'hFFF;  // everything

    // Frame order: row0 p0, row0 p1, row1 p0, row1 p1; four columns each
    tbl = '{
      '{3'd0, 6'b100000}, '{3'd1, 6'b000000}, '{3'd2, 6'b000000}, '{3'd3, 6'b000000},
      '{3'd0, 6'b000000}, '{3'd1, 6'b000000}, '{3'd2, 6'b001000}, '{3'd3, 6'b000000},
      '{3'd4, 6'b000000}, '{3'd5, 6'b000000}, '{3'd6, 6'b000000}, '{3'd7, 6'b111111},
      '{3'd4, 6'b000000}, '{3'd5, 6'b000010}, '{3'd6, 6'b000000}, '{3'd7, 6'b111111}
    };

    // Reset values
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_oe_n", int'(hub_oe_n), 1);
    chk("rst_rd_en", int'(fb_rd_en), 0);
    chk("rst_hub_clk", int'(hub_clk), 0);
    chk("rst_lat", int'(hub_lat), 0);
    chk("rst_rgb", int'(hub_rgb), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    reset = 1'b0;

    // Idle with enable low
    capture(20);
    chk("idle_rd_en", count(0, 0, 20), 0);
    chk("idle_lat", count(2, 0, 20), 0);
    chk("idle_clk_high", count(1, 0, 20), 0);
    chk("idle_oe_low", count(3, 0, 20), 0);

    // Full frame from the first FETCH (index 0)
    enable = 1'b1;
    capture(120);
    chk("first_fetch_idx", next_idx(0, 0), 0);
    chk("p0_clk_rises", count(1, 0, 23), 4);
    chk("p0_lat_cycles", count(2, 0, 23), 2);
    chk("p0_oe_low", count(3, 0, 23), exp_on(0));
    chk("p0_first_oe_idx", next_idx(3, 0), 15);
    chk("p0_len", next_idx(0, 13), 23);
    chk("p1_oe_low", count(3, 23, 54), exp_on(1));
    chk("p1_len", next_idx(0, 36) - 23, 31);
    chk("row0_hub_addr", int'(tr_haddr[20]), 0);
    chk("row1_hub_addr", int'(tr_haddr[72]), 1);
    chk("frame_done_count", count(4, 0, 120), 1);
    chk("frame_done_at_108", int'(tr_done[108]), 1);
    chk("restart_rd_en", int'(tr_rd[108]), 1);
    chk("restart_addr", int'(tr_faddr[108]), 0);

    // Per-column fetch address and shifted plane bits at each hub_clk rise
    k = 0;
    for (int i = 0; i < 16; i++) begin
      k = next_idx(0, k);
      if (k < 0) begin
        chk($sformatf("vec%0d_fetch_found", i), 0, 1);
        break;
      end
      chk($sformatf("vec%0d_addr", i), int'(tr_faddr[k]), int'(tbl[i].addr));
      kc = next_idx(1, k);
      if (kc < 0) chk($sformatf("vec%0d_clk_found", i), 0, 1);
      else chk($sformatf("vec%0d_rgb", i), int'(tr_rgb[kc]), int'(tbl[i].rgb));
      k = k + 1;
    end

    // Drop enable during row 1 plane 0 shift
    do_reset();
    enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (fb_rd_en && fb_addr == 3'd4) found = 1'b1;
    end
    chk("drop_reached_row1", int'(found), 1);
    @(negedge clk);
    enable = 1'b0;
    capture(80);
    chk("drop_remaining_fetches", count(0, 0, 80), 3);
    chk("drop_lat_cycles", count(2, 0, 80), 2);
    chk("drop_oe_low", count(3, 0, 80), exp_on(0));
    chk("drop_idle_oe_low", count(3, 21, 80), 0);
    chk("drop_idle_rd_en", count(0, 21, 80), 0);

    // Reset in the middle of row 1 DISPLAY
    do_reset();
    enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (hub_addr == 1'b1 && !hub_oe_n) found = 1'b1;
    end
    chk("rstmid_reached_display", int'(found), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rstmid_oe_n", int'(hub_oe_n), 1);
    chk("rstmid_hub_addr", int'(hub_addr), 0);
    chk("rstmid_lat", int'(hub_lat), 0);
    chk("rstmid_rd_en", int'(fb_rd_en), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rstmid_restart_rd_en", int'(fb_rd_en), 1);
    chk("rstmid_restart_addr", int'(fb_addr), 0);

`ifdef HUB75_BRIGHTNESS_EN
    brightness = 8'd128;
    do_reset();
    enable = 1'b1;
    capture(120);
    chk("br128_p0_oe_low", count(3, 0, 23), 4);
    chk("br128_p1_oe_low", count(3, 23, 54), 8);
    chk("br128_p1_len", next_idx(0, 36) - 23, 31);

    brightness = 8'd0;
    do_reset();
    enable = 1'b1;
    capture(120);
    chk("br0_oe_low", count(3, 0, 120), 0);
    chk("br0_p1_len", next_idx(0, 36) - 23, 31);
    chk("br0_frame_done_at_108", int'(tr_done[108]), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
